// File: rtl/xbar_allocator.sv
// Switch allocator: per-output round-robin arbitration with wormhole locking,
// driving the crossbar crosspoint enable matrix (bit i*N_out+j joins input i to output j).
module xbar_allocator #(
    parameter int M_in   = 28,
    parameter int N_out  = 7,
    parameter int PORT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [M_in-1:0]         req_valid,
    input  logic [M_in*PORT_W-1:0]  req_port,
    input  logic [M_in-1:0]         req_tail,
    input  logic [N_out-1:0]        out_ready,
    output logic [M_in-1:0]         grant,
    output logic [M_in*N_out-1:0]   xpoints_enable
);

    localparam int IDX_W = (M_in > 1) ? $clog2(M_in) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                 state_q  [N_out];
    state_e                 state_d  [N_out];
    logic [IDX_W-1:0]       owner_q  [N_out];
    logic [IDX_W-1:0]       owner_d  [N_out];
    logic [IDX_W-1:0]       rr_ptr_q [N_out];
    logic [IDX_W-1:0]       rr_ptr_d [N_out];
    logic [M_in*N_out-1:0]  xp_q;
    logic [M_in*N_out-1:0]  xp_d;

    logic [M_in-1:0]             busy;
    logic [N_out-1:0][M_in-1:0]  cand;
    logic [N_out-1:0]            win_valid;
    logic [IDX_W-1:0]            win_idx [N_out];
    logic [N_out-1:0]            release_out;

    assign xpoints_enable = xp_q;

    // An input that already owns a locked output may not compete for another one.
    always_comb begin
        for (int i = 0; i < M_in; i++) begin
            busy[i] = |xp_q[i*N_out +: N_out];
        end
        for (int j = 0; j < N_out; j++) begin
            for (int i = 0; i < M_in; i++) begin
                cand[j][i] = req_valid[i] && !busy[i] &&
                             (req_port[i*PORT_W +: PORT_W] == PORT_W'(j));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < M_in; i++) begin
            grant[i] = req_valid[i] & (|(xp_q[i*N_out +: N_out] & out_ready));
        end
    end

    // Round-robin search starting at rr_ptr and wrapping past the last input.
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < N_out; j++) begin
            win_valid[j] = 1'b0;
            win_idx[j]   = '0;
            for (int k = 0; k < M_in; k++) begin
                idx = int'(rr_ptr_q[j]) + k;
                if (idx >= M_in) begin
                    idx = idx - M_in;
                end
                if (!win_valid[j] && cand[j][idx]) begin
                    win_valid[j] = 1'b1;
                    win_idx[j]   = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_out; j++) begin
            release_out[j] = (state_q[j] == LOCKED) && out_ready[j] &&
                             req_valid[owner_q[j]] && req_tail[owner_q[j]];
        end
    end

    always_comb begin
        xp_d = xp_q;
        for (int j = 0; j < N_out; j++) begin
            state_d[j]  = state_q[j];
            owner_d[j]  = owner_q[j];
            rr_ptr_d[j] = rr_ptr_q[j];
            case (state_q[j])
                IDLE: begin
                    if (win_valid[j]) begin
                        state_d[j] = LOCKED;
                        owner_d[j] = win_idx[j];
                        xp_d[int'(win_idx[j])*N_out + j] = 1'b1;
                    end
                end
                LOCKED: begin
                    if (release_out[j]) begin
                        state_d[j] = IDLE;
                        xp_d[int'(owner_q[j])*N_out + j] = 1'b0;
                        rr_ptr_d[j] = (owner_q[j] == IDX_W'(M_in-1)) ? '0
                                                                     : owner_q[j] + IDX_W'(1);
                    end
                end
                default: begin
                    state_d[j] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_out; j++) begin
                state_q[j]  <= IDLE;
                owner_q[j]  <= '0;
                rr_ptr_q[j] <= '0;
            end
            xp_q <= '0;
        end else begin
            for (int j = 0; j < N_out; j++) begin
                state_q[j]  <= state_d[j];
                owner_q[j]  <= owner_d[j];
                rr_ptr_q[j] <= rr_ptr_d[j];
            end
            xp_q <= xp_d;
        end
    end

    // Crossbar legality: one input per output, one output per input, grants only on enables.
    for (genvar j = 0; j < N_out; j++) begin : g_col
        logic [M_in-1:0] col;
        for (genvar i = 0; i < M_in; i++) begin : g_bit
            assign col[i] = xp_q[i*N_out + j];
        end
        a_col_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(col));
    end

    for (genvar i = 0; i < M_in; i++) begin : g_row
        a_row_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                       $onehot0(xp_q[i*N_out +: N_out]));
        a_grant_enabled: assert property (@(posedge clk) disable iff (!rst_n)
                                          grant[i] |-> (|xp_q[i*N_out +: N_out]));
    end

endmodule

// File: tb/tb_xbar_allocator.sv
// Directed testbench for xbar_allocator: locking, round-robin order, stalls,
// port changes mid-packet, invalid ports and asynchronous reset.
module tb_xbar_allocator;

    localparam int M_IN   = 28;
    localparam int N_OUT  = 7;
    localparam int PORT_W = 3;

    logic                    clk;
    logic                    rst_n;
    logic [M_IN-1:0]         req_valid;
    logic [M_IN*PORT_W-1:0]  req_port;
    logic [M_IN-1:0]         req_tail;
    logic [N_OUT-1:0]        out_ready;
    logic [M_IN-1:0]         grant;
    logic [M_IN*N_OUT-1:0]   xpoints_enable;

    int checks;
    int failures;

    xbar_allocator #(
        .M_in   (M_IN),
        .N_out  (N_OUT),
        .PORT_W (PORT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_port       (req_port),
        .req_tail       (req_tail),
        .out_ready      (out_ready),
        .grant          (grant),
        .xpoints_enable (xpoints_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] xbit(input int i, input int j);
        logic [255:0] r;
        r = '0;
        r[i*N_OUT + j] = 1'b1;
        return r;
    endfunction

    function automatic logic [255:0] gbit(input int i);
        logic [255:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic applyStimulus(input int i, input logic v, input int p, input logic t);
        req_valid[i]               = v;
        req_port[i*PORT_W +: PORT_W] = PORT_W'(p);
        req_tail[i]                = t;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_port  = '0;
        req_tail  = '0;
        out_ready = '1;
        #1;
        checkOutput("reset_xp", 256'(xpoints_enable), '0);
        checkOutput("reset_grant", 256'(grant), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int t2_order [8] = '{-1, 0, -1, 5, -1, 27, -1, 0};

    initial begin
        checks   = 0;
        failures = 0;

        // Basic lock, transfer, tail release and rr_ptr advance past the owner.
        doReset();
        nextCycle();
        applyStimulus(3, 1'b1, 2, 1'b0);
        @(negedge clk);
        checkOutput("t1_c0_xp", 256'(xpoints_enable), '0);
        checkOutput("t1_c0_grant", 256'(grant), '0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_c1_xp", 256'(xpoints_enable), xbit(3, 2));
        checkOutput("t1_c1_grant", 256'(grant), gbit(3));
        nextCycle();
        @(negedge clk);
        checkOutput("t1_c2_grant", 256'(grant), gbit(3));
        nextCycle();
        applyStimulus(3, 1'b1, 2, 1'b1);
        @(negedge clk);
        checkOutput("t1_c3_grant", 256'(grant), gbit(3));
        nextCycle();
        applyStimulus(3, 1'b1, 2, 1'b0);
        applyStimulus(5, 1'b1, 2, 1'b0);
        @(negedge clk);
        checkOutput("t1_c4_xp", 256'(xpoints_enable), '0);
        checkOutput("t1_c4_grant", 256'(grant), '0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_c5_xp", 256'(xpoints_enable), xbit(5, 2));
        checkOutput("t1_c5_grant", 256'(grant), gbit(5));

        // Single-flit packets from 0, 5, 27 to output 6: order 0,5,27,0 with dead cycles.
        doReset();
        nextCycle();
        applyStimulus(0, 1'b1, 6, 1'b1);
        applyStimulus(5, 1'b1, 6, 1'b1);
        applyStimulus(27, 1'b1, 6, 1'b1);
        @(negedge clk);
        checkOutput("t2_c0_grant", 256'(grant), '0);
        for (int c = 1; c < 8; c++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("t2_c%0d_grant", c), 256'(grant),
                        (t2_order[c] < 0) ? 256'(0) : gbit(t2_order[c]));
            if (c == 5) begin
                checkOutput("t2_c5_xp", 256'(xpoints_enable), xbit(27, 6));
            end
        end

        // Lock held through req_valid bubbles and out_ready stalls; input 9 waits.
        doReset();
        nextCycle();
        applyStimulus(5, 1'b1, 1, 1'b0);
        applyStimulus(9, 1'b1, 1, 1'b0);
        @(negedge clk);
        checkOutput("t3_c0_xp", 256'(xpoints_enable), '0);
        nextCycle();
        @(negedge clk);
        checkOutput("t3_c1_xp", 256'(xpoints_enable), xbit(5, 1));
        checkOutput("t3_c1_grant", 256'(grant), gbit(5));
        for (int c = 2; c < 5; c++) begin
            nextCycle();
            applyStimulus(5, 1'b0, 1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("t3_c%0d_xp", c), 256'(xpoints_enable), xbit(5, 1));
            checkOutput($sformatf("t3_c%0d_grant", c), 256'(grant), '0);
        end
        for (int c = 5; c < 7; c++) begin
            nextCycle();
            applyStimulus(5, 1'b1, 1, 1'b0);
            out_ready[1] = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("t3_c%0d_xp", c), 256'(xpoints_enable), xbit(5, 1));
            checkOutput($sformatf("t3_c%0d_grant", c), 256'(grant), '0);
        end
        nextCycle();
        out_ready[1] = 1'b1;
        applyStimulus(5, 1'b1, 1, 1'b1);
        @(negedge clk);
        checkOutput("t3_c7_xp", 256'(xpoints_enable), xbit(5, 1));
        checkOutput("t3_c7_grant", 256'(grant), gbit(5));
        nextCycle();
        applyStimulus(5, 1'b0, 1, 1'b0);
        @(negedge clk);
        checkOutput("t3_c8_xp", 256'(xpoints_enable), '0);
        checkOutput("t3_c8_grant", 256'(grant), '0);
        nextCycle();
        @(negedge clk);
        checkOutput("t3_c9_xp", 256'(xpoints_enable), xbit(9, 1));
        checkOutput("t3_c9_grant", 256'(grant), gbit(9));

        // Owner changes req_port mid-packet: lock holds, owner excluded from output 3.
        doReset();
        nextCycle();
        applyStimulus(4, 1'b1, 0, 1'b0);
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("t4_c1_xp", 256'(xpoints_enable), xbit(4, 0));
        checkOutput("t4_c1_grant", 256'(grant), gbit(4));
        nextCycle();
        applyStimulus(4, 1'b1, 3, 1'b0);
        applyStimulus(10, 1'b1, 3, 1'b0);
        @(negedge clk);
        checkOutput("t4_c2_xp", 256'(xpoints_enable), xbit(4, 0));
        checkOutput("t4_c2_grant", 256'(grant), gbit(4));
        nextCycle();
        applyStimulus(4, 1'b1, 3, 1'b1);
        @(negedge clk);
        checkOutput("t4_c3_xp", 256'(xpoints_enable), xbit(4, 0) | xbit(10, 3));
        checkOutput("t4_c3_grant", 256'(grant), gbit(4) | gbit(10));
        nextCycle();
        applyStimulus(4, 1'b1, 3, 1'b0);
        @(negedge clk);
        checkOutput("t4_c4_xp", 256'(xpoints_enable), xbit(10, 3));
        checkOutput("t4_c4_grant", 256'(grant), gbit(10));

        // Out-of-range port is never enabled or granted.
        doReset();
        nextCycle();
        applyStimulus(7, 1'b1, 7, 1'b0);
        applyStimulus(8, 1'b1, 6, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_c%0d_row7", c),
                        256'(xpoints_enable[7*N_OUT +: N_OUT]), '0);
            checkOutput($sformatf("t5_c%0d_grant7", c), 256'(grant[7]), '0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t5_xp", 256'(xpoints_enable), xbit(8, 6));

        // Asynchronous reset mid-packet clears everything and rr_ptr restarts at 0.
        doReset();
        nextCycle();
        applyStimulus(20, 1'b1, 0, 1'b1);
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_c1_grant", 256'(grant), gbit(20));
        nextCycle();
        applyStimulus(20, 1'b0, 0, 1'b0);
        applyStimulus(1, 1'b1, 0, 1'b0);
        applyStimulus(2, 1'b1, 1, 1'b0);
        applyStimulus(3, 1'b1, 2, 1'b0);
        @(negedge clk);
        checkOutput("t6_c2_xp", 256'(xpoints_enable), '0);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_c3_xp", 256'(xpoints_enable), xbit(1, 0) | xbit(2, 1) | xbit(3, 2));
        checkOutput("t6_c3_grant", 256'(grant), gbit(1) | gbit(2) | gbit(3));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_xp", 256'(xpoints_enable), '0);
        checkOutput("t6_async_grant", 256'(grant), '0);
        applyStimulus(22, 1'b1, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("t6_rearb_xp", 256'(xpoints_enable), xbit(1, 0) | xbit(2, 1) | xbit(3, 2));
        checkOutput("t6_rearb_grant", 256'(grant), gbit(1) | gbit(2) | gbit(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
